// File: rtl/dcache_if.sv
// dcache_if: AGU request/response and backing-memory signals of the data cache.
interface dcache_if #(parameter int WIDTH_MEM = 4);
  logic i_val;
  logic i_we;
  logic i_kill;
  logic [WIDTH_MEM-1:0] i_addr;
  logic [31:0] i_data;
  logic o_val;
  logic o_nack;
  logic [31:0] o_data;
  logic mem_o_req;
  logic mem_o_we;
  logic [WIDTH_MEM-1:0] mem_o_addr;
  logic [31:0] mem_o_data;
  logic mem_i_ack;
  logic [31:0] mem_i_data;
  modport master (
    output i_val, i_we, i_kill, i_addr, i_data, mem_i_ack, mem_i_data,
    input o_val, o_nack, o_data, mem_o_req, mem_o_we, mem_o_addr, mem_o_data
  );
  modport slave (
    input i_val, i_we, i_kill, i_addr, i_data, mem_i_ack, mem_i_data,
    output o_val, o_nack, o_data, mem_o_req, mem_o_we, mem_o_addr, mem_o_data
  );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, one-word-per-line data cache with nack/replay.
module dcache #(
  parameter int WIDTH_MEM = 4,
  parameter int WIDTH_LINE = 2
) (
  input logic i_clk,
  input logic i_rst,
  dcache_if.slave bus
);
  localparam int WIDTH_TAG = WIDTH_MEM - WIDTH_LINE;
  localparam int LINES = 2 ** WIDTH_LINE;
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t state;
  logic [LINES-1:0] valid;
  logic [WIDTH_TAG-1:0] tags [LINES];
  logic [31:0] lines [LINES];
  logic req, hit;
  logic [WIDTH_LINE-1:0] idx, fidx;
  logic [WIDTH_TAG-1:0] tg, ftag;
  assign req = bus.i_val & ~bus.i_kill;
  assign idx = bus.i_addr[WIDTH_LINE-1:0];
  assign tg = bus.i_addr[WIDTH_MEM-1:WIDTH_LINE];
  assign fidx = bus.mem_o_addr[WIDTH_LINE-1:0];
  assign ftag = bus.mem_o_addr[WIDTH_MEM-1:WIDTH_LINE];
  assign hit = valid[idx] && (tags[idx] == tg);
  // tag/data arrays carry no reset; only the valid bits do
  always_ff @(posedge i_clk)
    if (!i_rst) begin
      if (state == IDLE && req && bus.i_we && hit)
        lines[idx] <= bus.i_data;
      else if (state == FILL && bus.mem_i_ack) begin
        lines[fidx] <= bus.mem_i_data;
        tags[fidx] <= ftag;
      end
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      valid <= '0;
      bus.o_val <= 1'b0;
      bus.o_nack <= 1'b0;
      bus.o_data <= '0;
      bus.mem_o_req <= 1'b0;
      bus.mem_o_we <= 1'b0;
      bus.mem_o_addr <= '0;
      bus.mem_o_data <= '0;
    end else begin
      bus.o_val <= req;
      bus.o_nack <= req;
      case (state)
        IDLE:
          if (req) begin
            bus.mem_o_req <= bus.i_we | ~hit;
            bus.mem_o_we <= bus.i_we;
            bus.mem_o_addr <= bus.i_addr;
            if (bus.i_we) begin
              bus.o_nack <= 1'b0;
              bus.mem_o_data <= bus.i_data;
              state <= WRITE;
            end else if (hit) begin
              bus.o_nack <= 1'b0;
              bus.o_data <= lines[idx];
            end else
              state <= FILL;
          end
        FILL:
          if (bus.mem_i_ack) begin
            valid[fidx] <= 1'b1;
            bus.mem_o_req <= 1'b0;
            state <= IDLE;
          end
        default:
          if (bus.mem_i_ack) begin
            bus.mem_o_req <= 1'b0;
            state <= IDLE;
          end
      endcase
    end
endmodule
